// File: rtl/stream_sched_pkg.sv
// Shared types and constants for the two-source packet scheduler.
package stream_sched_pkg;

    localparam int   NUM_SRC    = 2;
    localparam logic RR_RESET   = 1'b1;
    localparam int   DATA_W_DEF = 8;

    typedef logic [$clog2(NUM_SRC)-1:0] src_t;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } state_t;

endpackage

// File: rtl/stream_pkt_scheduler_if.sv
// Source streams, datapath stream and per-packet config/status of the scheduler.
interface stream_pkt_scheduler_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s0_data;
    logic              s0_valid;
    logic              s0_last;
    logic              s0_ready;
    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;
    logic              s1_last;
    logic              s1_ready;
    logic [DATA_W-1:0] k0;
    logic [DATA_W-1:0] len0;
    logic [DATA_W-1:0] k1;
    logic [DATA_W-1:0] len1;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;
    logic [DATA_W-1:0] cfg_k;
    logic [DATA_W-1:0] cfg_len;
    logic              grant;
    logic              busy;
    logic              trunc;

    // Scheduler side: drives the datapath stream, source readies and status.
    modport master (
        input  s0_data, s0_valid, s0_last, s1_data, s1_valid, s1_last,
        input  k0, len0, k1, len1, m_ready,
        output s0_ready, s1_ready, m_data, m_valid, m_last,
        output cfg_k, cfg_len, grant, busy, trunc
    );

    modport slave (
        output s0_data, s0_valid, s0_last, s1_data, s1_valid, s1_last,
        output k0, len0, k1, len1, m_ready,
        input  s0_ready, s1_ready, m_data, m_valid, m_last,
        input  cfg_k, cfg_len, grant, busy, trunc
    );

endinterface

// File: rtl/rr_grant2.sv
// Two-requester round-robin arbiter; on a tie the source not served last wins.
module rr_grant2 (
    input  logic req0,
    input  logic req1,
    input  logic rr_last,
    output logic gnt_idx,
    output logic gnt_vld
);

    always_comb begin
        gnt_vld = req0 | req1;
        gnt_idx = 1'b0;
        if (req0 && req1) begin
            gnt_idx = ~rr_last;
        end else if (req1) begin
            gnt_idx = 1'b1;
        end
    end

endmodule

// File: rtl/stream_pkt_scheduler.sv
// Packet-granular round-robin scheduler feeding one k/len packet processor
// from two AXI-Stream sources, with length-limit truncation and drain.
module stream_pkt_scheduler
    import stream_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    stream_pkt_scheduler_if.master bus
);

    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    state_t            state_q, state_d;
    src_t              grant_q, grant_d;
    logic              rr_last_q, rr_last_d;
    logic [DATA_W-1:0] cfg_k_q, cfg_k_d;
    logic [DATA_W-1:0] cfg_len_q, cfg_len_d;
    logic [DATA_W-1:0] beat_cnt_q, beat_cnt_d;

    logic              gnt_idx, gnt_vld;
    logic [DATA_W-1:0] k_g, len_g;
    logic [DATA_W-1:0] sg_data;
    logic              sg_valid, sg_last, sg_ready;
    logic              forced_last;
    logic [DATA_W-1:0] m_data;
    logic              m_valid, m_last, trunc;

    // k must index inside the packet, so it saturates at len-1 when a limit exists.
    function automatic logic [DATA_W-1:0] clamp_k(input logic [DATA_W-1:0] k,
                                                  input logic [DATA_W-1:0] len);
        if ((len != '0) && (k >= len)) begin
            return len - ONE;
        end
        return k;
    endfunction

    rr_grant2 u_rr_grant2 (
        .req0    (bus.s0_valid),
        .req1    (bus.s1_valid),
        .rr_last (rr_last_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign k_g         = gnt_idx ? bus.k1   : bus.k0;
    assign len_g       = gnt_idx ? bus.len1 : bus.len0;
    assign sg_data     = grant_q ? bus.s1_data  : bus.s0_data;
    assign sg_valid    = grant_q ? bus.s1_valid : bus.s0_valid;
    assign sg_last     = grant_q ? bus.s1_last  : bus.s0_last;
    assign forced_last = (cfg_len_q != '0) && (beat_cnt_q == (cfg_len_q - ONE));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_last_d  = rr_last_q;
        cfg_k_d    = cfg_k_q;
        cfg_len_d  = cfg_len_q;
        beat_cnt_d = beat_cnt_q;
        sg_ready   = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_data     = '0;
        trunc      = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    grant_d    = gnt_idx;
                    cfg_len_d  = len_g;
                    cfg_k_d    = clamp_k(k_g, len_g);
                    beat_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                m_valid  = sg_valid;
                m_data   = sg_data;
                m_last   = sg_last | forced_last;
                sg_ready = bus.m_ready;
                if (sg_valid && bus.m_ready) begin
                    beat_cnt_d = beat_cnt_q + ONE;
                    // A real end on the limit beat is a normal end, not a truncation.
                    if (sg_last) begin
                        state_d   = IDLE;
                        rr_last_d = grant_q;
                    end else if (forced_last) begin
                        state_d   = DRAIN;
                        trunc     = 1'b1;
                        rr_last_d = grant_q;
                    end
                end
            end
            DRAIN: begin
                sg_ready = 1'b1;
                if (sg_valid && sg_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_last_q  <= RR_RESET;
            cfg_k_q    <= '0;
            cfg_len_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_last_q  <= rr_last_d;
            cfg_k_q    <= cfg_k_d;
            cfg_len_q  <= cfg_len_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.s0_ready = sg_ready & ~grant_q;
    assign bus.s1_ready = sg_ready &  grant_q;
    assign bus.m_data   = m_data;
    assign bus.m_valid  = m_valid;
    assign bus.m_last   = m_last;
    assign bus.trunc    = trunc;
    assign bus.cfg_k    = cfg_k_q;
    assign bus.cfg_len  = cfg_len_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_stream_pkt_scheduler.sv
// Bench for stream_pkt_scheduler: cycle vector table, corner sequences and a
// randomized two-source run scored against a packet-level reference model.
module tb_stream_pkt_scheduler;

    localparam int NP = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stream_pkt_scheduler_if #(.DATA_W(8)) bus ();

    stream_pkt_scheduler #(.DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        v0;
        logic [7:0]  d0;
        logic        l0;
        logic        v1;
        logic [7:0]  d1;
        logic        l1;
        logic        mr;
        logic [7:0]  k0;
        logic [7:0]  n0;
        logic [7:0]  k1;
        logic [7:0]  n1;
        logic [30:0] e;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic [7:0] k;
        logic [7:0] len;
        logic       g;
    } exp_t;

    int nvec = 0;
    int nerr = 0;

    vec_t tbl[$];
    exp_t q[$];

    int         cur_p[2];
    int         cur_b[2];
    logic       vld[2];
    int         plen[2][NP];
    logic [7:0] pk[2][NP];
    logic [7:0] pcl[2][NP];
    logic [7:0] pd[2][NP][10];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [30:0] E(logic v, logic [7:0] d, logic l, logic r0, logic r1,
                                      logic b, logic t, logic g, logic [7:0] k, logic [7:0] n);
        return {v, d, l, r0, r1, b, t, g, k, n};
    endfunction

    function automatic vec_t V(logic v0, logic [7:0] d0, logic l0, logic v1, logic [7:0] d1,
                               logic l1, logic mr, logic [7:0] k0, logic [7:0] n0,
                               logic [7:0] k1, logic [7:0] n1, logic [30:0] e);
        vec_t r;
        r.v0 = v0; r.d0 = d0; r.l0 = l0; r.v1 = v1; r.d1 = d1; r.l1 = l1; r.mr = mr;
        r.k0 = k0; r.n0 = n0; r.k1 = k1; r.n1 = n1; r.e = e;
        return r;
    endfunction

    function automatic logic [30:0] observe();
        return {bus.m_valid, bus.m_data, bus.m_last, bus.s0_ready, bus.s1_ready,
                bus.busy, bus.trunc, bus.grant, bus.cfg_k, bus.cfg_len};
    endfunction

    function automatic logic [25:0] src_beat(int s);
        int p;
        int b;
        p = cur_p[s];
        b = cur_b[s];
        if (p >= NP) return '0;
        return {vld[s], pd[s][p][b], 1'(b == plen[s][p] - 1), pk[s][p], pcl[s][p]};
    endfunction

    task automatic drive_rand();
        {bus.s0_valid, bus.s0_data, bus.s0_last, bus.k0, bus.len0} = src_beat(0);
        {bus.s1_valid, bus.s1_data, bus.s1_last, bus.k1, bus.len1} = src_beat(1);
    endtask

    task automatic advance(input int s, input logic a);
        if (a) begin
            if (cur_b[s] == plen[s][cur_p[s]] - 1) begin
                cur_p[s]++;
                cur_b[s] = 0;
                vld[s]   = 1'b1;
            end else begin
                cur_b[s]++;
                vld[s] = ($urandom_range(3) != 0);
            end
        end else if (!vld[s]) begin
            vld[s] = 1'($urandom_range(1));
        end
    endtask

    task automatic clear_inputs();
        bus.s0_valid = 0; bus.s0_data = 0; bus.s0_last = 0;
        bus.s1_valid = 0; bus.s1_data = 0; bus.s1_last = 0;
        bus.k0 = 0; bus.len0 = 0; bus.k1 = 0; bus.len1 = 0;
        bus.m_ready = 0;
    endtask

    initial begin
        int   nb;
        int   b;
        int   exp_tr;
        int   got_tr;
        int   n;
        logic acc;
        logic acc0;
        logic acc1;
        logic done;
        logic [7:0] kk;
        exp_t e;

        rst = 1'b0;
        clear_inputs();

        // Basic 4-beat packet from s0 (k=2, len=8)
        tbl.push_back(V(1, 8'h01, 0, 0, 8'h00, 0, 1, 2, 8, 1, 3, E(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(V(1, 8'h01, 0, 0, 8'h00, 0, 1, 2, 8, 1, 3, E(1, 8'h01, 0, 1, 0, 1, 0, 0, 2, 8)));
        tbl.push_back(V(1, 8'h02, 0, 0, 8'h00, 0, 1, 2, 8, 1, 3, E(1, 8'h02, 0, 1, 0, 1, 0, 0, 2, 8)));
        tbl.push_back(V(1, 8'h03, 0, 0, 8'h00, 0, 1, 2, 8, 1, 3, E(1, 8'h03, 0, 1, 0, 1, 0, 0, 2, 8)));
        tbl.push_back(V(1, 8'h04, 1, 0, 8'h00, 0, 1, 2, 8, 1, 3, E(1, 8'h04, 1, 1, 0, 1, 0, 0, 2, 8)));
        tbl.push_back(V(0, 8'h00, 0, 0, 8'h00, 0, 1, 2, 8, 1, 3, E(0, 8'h00, 0, 0, 0, 0, 0, 0, 2, 8)));
        // s1 six beats cut at len=3, then drained
        tbl.push_back(V(0, 8'h00, 0, 1, 8'hA0, 0, 1, 2, 8, 1, 3, E(0, 8'h00, 0, 0, 0, 0, 0, 0, 2, 8)));
        tbl.push_back(V(0, 8'h00, 0, 1, 8'hA0, 0, 1, 2, 8, 1, 3, E(1, 8'hA0, 0, 0, 1, 1, 0, 1, 1, 3)));
        tbl.push_back(V(0, 8'h00, 0, 1, 8'hA1, 0, 1, 2, 8, 1, 3, E(1, 8'hA1, 0, 0, 1, 1, 0, 1, 1, 3)));
        tbl.push_back(V(0, 8'h00, 0, 1, 8'hA2, 0, 1, 2, 8, 1, 3, E(1, 8'hA2, 1, 0, 1, 1, 1, 1, 1, 3)));
        tbl.push_back(V(0, 8'h00, 0, 1, 8'hA3, 0, 1, 2, 8, 1, 3, E(0, 8'h00, 0, 0, 1, 1, 0, 1, 1, 3)));
        tbl.push_back(V(0, 8'h00, 0, 1, 8'hA4, 0, 1, 2, 8, 1, 3, E(0, 8'h00, 0, 0, 1, 1, 0, 1, 1, 3)));
        tbl.push_back(V(0, 8'h00, 0, 1, 8'hA5, 1, 1, 2, 8, 1, 3, E(0, 8'h00, 0, 0, 1, 1, 0, 1, 1, 3)));
        tbl.push_back(V(0, 8'h00, 0, 0, 8'h00, 0, 1, 2, 8, 1, 3, E(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 3)));
        // Backpressure 1,0,0,1 on a 3-beat packet; k=5 clamps to 2; last meets len (no trunc)
        tbl.push_back(V(1, 8'hB0, 0, 0, 8'h00, 0, 1, 5, 3, 1, 3, E(0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 3)));
        tbl.push_back(V(1, 8'hB0, 0, 0, 8'h00, 0, 1, 5, 3, 1, 3, E(1, 8'hB0, 0, 1, 0, 1, 0, 0, 2, 3)));
        tbl.push_back(V(1, 8'hB1, 0, 0, 8'h00, 0, 0, 5, 3, 1, 3, E(1, 8'hB1, 0, 0, 0, 1, 0, 0, 2, 3)));
        tbl.push_back(V(1, 8'hB1, 0, 0, 8'h00, 0, 0, 5, 3, 1, 3, E(1, 8'hB1, 0, 0, 0, 1, 0, 0, 2, 3)));
        tbl.push_back(V(1, 8'hB1, 0, 0, 8'h00, 0, 1, 5, 3, 1, 3, E(1, 8'hB1, 0, 1, 0, 1, 0, 0, 2, 3)));
        tbl.push_back(V(1, 8'hB2, 1, 0, 8'h00, 0, 1, 5, 3, 1, 3, E(1, 8'hB2, 1, 1, 0, 1, 0, 0, 2, 3)));
        // Tie after s0 was served: s1 wins, len1=0 leaves k1 unclamped
        tbl.push_back(V(1, 8'hC0, 0, 1, 8'hD0, 1, 1, 5, 3, 9, 0, E(0, 8'h00, 0, 0, 0, 0, 0, 0, 2, 3)));
        tbl.push_back(V(1, 8'hC0, 0, 1, 8'hD0, 1, 1, 5, 3, 9, 0, E(1, 8'hD0, 1, 0, 1, 1, 0, 1, 9, 0)));
        // len=1 with s_last low: forced last on beat 0, then drain
        tbl.push_back(V(1, 8'hC0, 0, 0, 8'h00, 0, 1, 0, 1, 9, 0, E(0, 8'h00, 0, 0, 0, 0, 0, 1, 9, 0)));
        tbl.push_back(V(1, 8'hC0, 0, 0, 8'h00, 0, 1, 0, 1, 9, 0, E(1, 8'hC0, 1, 1, 0, 1, 1, 0, 0, 1)));
        tbl.push_back(V(1, 8'hC1, 1, 0, 8'h00, 0, 1, 0, 1, 9, 0, E(0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 1)));
        tbl.push_back(V(0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 1, 9, 0, E(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1)));

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            bus.s0_valid = tbl[i].v0; bus.s0_data = tbl[i].d0; bus.s0_last = tbl[i].l0;
            bus.s1_valid = tbl[i].v1; bus.s1_data = tbl[i].d1; bus.s1_last = tbl[i].l1;
            bus.m_ready  = tbl[i].mr;
            bus.k0 = tbl[i].k0; bus.len0 = tbl[i].n0; bus.k1 = tbl[i].k1; bus.len1 = tbl[i].n1;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 64'(observe()), 64'(tbl[i].e));
        end

        // 300-beat packet with len0=0: only the source's own last ends it
        @(posedge clk);
        #1;
        b  = 0;
        nb = 0;
        bus.k0 = 8'd5; bus.len0 = 8'd0;
        bus.s0_valid = 1; bus.s0_data = 8'd0; bus.s0_last = 0; bus.m_ready = 1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = bus.m_valid & bus.m_ready;
            if (acc) begin
                if (nb == 0) chk("len0 cfg_k", 64'(bus.cfg_k), 64'd5);
                chk("len0 beat", 64'({bus.m_data, bus.m_last}), 64'({8'(nb), 1'(nb == 299)}));
                nb++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                b++;
                if (b >= 300) begin
                    bus.s0_valid = 0;
                end else begin
                    bus.s0_data = 8'(b);
                    bus.s0_last = (b == 299);
                end
            end
            if (b >= 300) break;
        end
        chk("len0 beat count", 64'(nb), 64'd300);
        chk("len0 idle after", 64'(bus.busy), 64'd0);

        // Async reset in the middle of XFER
        bus.s0_valid = 1; bus.s0_data = 8'hE0; bus.s0_last = 0;
        @(posedge clk);
        #1;
        chk("pre-reset m_valid", 64'({bus.m_valid, bus.busy}), 64'b11);
        #2;
        rst = 1'b0;
        #1;
        chk("async reset outputs", 64'({bus.m_valid, bus.s0_ready, bus.busy, bus.m_data}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.s1_valid = 1; bus.s1_data = 8'hF0; bus.s1_last = 0;
        @(posedge clk);
        #1;
        chk("tie after reset", 64'({bus.busy, bus.grant}), 64'b10);

        // Randomized two-source run against the packet-level model
        rst = 1'b0;
        exp_tr = 0;
        for (int p = 0; p < NP; p++) begin
            for (int s = 0; s < 2; s++) begin
                plen[s][p] = $urandom_range(10, 1);
                pcl[s][p]  = 8'($urandom_range(8));
                pk[s][p]   = 8'($urandom_range(10));
                for (int j = 0; j < 10; j++) pd[s][p][j] = 8'($urandom_range(255));
            end
        end
        for (int p = 0; p < NP; p++) begin
            for (int s = 0; s < 2; s++) begin
                n = plen[s][p];
                if (pcl[s][p] != 0 && int'(pcl[s][p]) < plen[s][p]) begin
                    n = int'(pcl[s][p]);
                    exp_tr++;
                end
                kk = (pcl[s][p] != 0 && pk[s][p] >= pcl[s][p]) ? pcl[s][p] - 8'd1 : pk[s][p];
                for (int j = 0; j < n; j++) begin
                    e.d = pd[s][p][j]; e.l = (j == n - 1); e.k = kk; e.len = pcl[s][p]; e.g = 1'(s);
                    q.push_back(e);
                end
            end
        end
        for (int s = 0; s < 2; s++) begin
            cur_p[s] = 0;
            cur_b[s] = 0;
            vld[s]   = 1'b1;
        end
        drive_rand();
        bus.m_ready = 1;
        got_tr = 0;
        done   = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            acc0 = bus.s0_valid & bus.s0_ready;
            acc1 = bus.s1_valid & bus.s1_ready;
            if (bus.trunc) got_tr++;
            if (bus.m_valid && bus.m_ready) begin
                if (q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL rand extra beat: got data %0h, expected no beat", bus.m_data);
                end else begin
                    e = q.pop_front();
                    chk("rand beat", 64'({bus.m_data, bus.m_last, bus.cfg_k, bus.cfg_len, bus.grant}),
                        64'(e));
                end
            end
            @(posedge clk);
            #1;
            advance(0, acc0);
            advance(1, acc1);
            bus.m_ready = ($urandom_range(3) != 0);
            drive_rand();
            if (q.size() == 0 && cur_p[0] == NP && cur_p[1] == NP) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            nvec++;
            nerr++;
            $display("FAIL rand timeout: got %0d beats left, expected 0", q.size());
        end
        chk("rand trunc count", 64'(got_tr), 64'(exp_tr));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
